// File: rtl/uart_rx.sv
// ============================================================================
// Module   : uart_rx
// Purpose  : 16x-oversampling 8N1 UART receiver with valid/ready output and
//            framing/overrun error pulses. Define UART_RX_MAJORITY_EN for
//            2-of-3 majority sampling of each start/data/stop decision.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick_16x,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun_err
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] c_half_m1 = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] c_full_m1 = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] c_last_bit = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    DATA       = 3'd2,
    STOP       = 3'd3,
    BREAK_WAIT = 3'd4
  } state_e;

  state_e                 state_q;
  logic [CW-1:0]          cnt_q;
  logic [BW-1:0]          bit_idx_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic [DATA_BITS-1:0]   rx_data_q;
  logic                   rx_valid_q;
  logic                   frame_err_q;
  logic                   overrun_err_q;
  logic [1:0]             sync_q;
  logic                   w_rx_s;
  logic                   w_bit;
  logic [DATA_BITS:0]     w_shift;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx};
    end
  end

  assign w_rx_s = sync_q[1];

`ifdef UART_RX_MAJORITY_EN
  // rx_s seen on the two previous ticks, i.e. at cnt = target-2 and target-1
  logic [1:0] hist_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= 2'b11;
    end else if (tick_16x) begin
      hist_q <= {hist_q[0], w_rx_s};
    end
  end

  assign w_bit = (hist_q[1] & hist_q[0]) | (hist_q[1] & w_rx_s) | (hist_q[0] & w_rx_s);
`else
  assign w_bit = w_rx_s;
`endif

  assign w_shift = {w_bit, shift_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
      // Consumption; a delivery on the same cycle overrides this below
      if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end
      if (tick_16x) begin
        case (state_q)
          IDLE: begin
            if (!w_rx_s) begin
              state_q <= START;
              cnt_q   <= '0;
            end
          end
          START: begin
            if (cnt_q == c_half_m1) begin
              if (!w_bit) begin
                state_q   <= DATA;
                cnt_q     <= '0;
                bit_idx_q <= '0;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          DATA: begin
            if (cnt_q == c_full_m1) begin
              shift_q   <= w_shift[DATA_BITS:1];
              cnt_q     <= '0;
              bit_idx_q <= bit_idx_q + BW'(1);
              if (bit_idx_q == c_last_bit) begin
                state_q <= STOP;
              end
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          STOP: begin
            if (cnt_q == c_full_m1) begin
              cnt_q <= '0;
              if (w_bit) begin
                state_q <= IDLE;
                if (!rx_valid_q || rx_ready) begin
                  rx_data_q  <= shift_q;
                  rx_valid_q <= 1'b1;
                end else begin
                  overrun_err_q <= 1'b1;
                end
              end else begin
                frame_err_q <= 1'b1;
                state_q     <= BREAK_WAIT;
              end
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          BREAK_WAIT: begin
            if (w_rx_s) begin
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_err_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Directed plus random-byte bench for uart_rx (tick every 7 clk,
//            16 ticks per bit). Expected bytes come from the frame contents.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_16x = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b0;
  wire  [7:0] rx_data;
  wire        rx_valid;
  wire        frame_err;
  wire        overrun_err;

  int checks = 0;
  int errors = 0;
  int n_ferr = 0;
  int n_oerr = 0;
  int n_vrise = 0;
  logic valid_d = 1'b0;

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .tick_16x    (tick_16x),
    .rx          (rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .frame_err   (frame_err),
    .overrun_err (overrun_err)
  );

  always #5 clk = ~clk;

  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge clk);
      #2;
      tick_16x = (ph == 6);
      ph = (ph == 6) ? 0 : ph + 1;
    end
  end

  always @(negedge clk) begin
    if (frame_err) n_ferr++;
    if (overrun_err) n_oerr++;
    if (rx_valid && !valid_d) n_vrise++;
    valid_d = rx_valid;
  end

  initial begin
    #800000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next tick edge, optionally holding rx_ready
  // high for exactly that tick cycle.
  task automatic next_tick(input logic pulse_ready);
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!tick_16x && guard < 20);
    if (!tick_16x) chk("tick_timeout", {31'd0, tick_16x}, 32'd1);
    if (pulse_ready) rx_ready = 1'b1;
    @(posedge clk);
    #1;
    if (pulse_ready) rx_ready = 1'b0;
  endtask

  task automatic idle_ticks(input int n);
    rx = 1'b1;
    repeat (n) next_tick(1'b0);
  endtask

  // Drives one frame, one level per 16 ticks. Detection is tick 1, so the
  // stop bit is sampled on tick 153.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int flip_t,
                            input int rst_t, input logic pulse_ready,
                            output logic pre_v, output logic v1, output logic v2,
                            output logic f1, output logic o1, output logic [7:0] d1,
                            output logic [10:0] after_rst);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    pre_v = 1'bx; v1 = 1'bx; v2 = 1'bx; f1 = 1'bx; o1 = 1'bx; d1 = 'x; after_rst = 'x;
    for (int t = 1; t <= 160; t++) begin
      rx = bits[(t - 1) / 16] ^ (t == flip_t);
      if (t == 153) pre_v = rx_valid;
      next_tick(pulse_ready && (t == 153));
      if (t == 153) begin
        v1 = rx_valid; d1 = rx_data; f1 = frame_err; o1 = overrun_err;
        @(posedge clk);
        #1;
        v2 = rx_valid;
      end
      if (t == rst_t) begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        after_rst = {rx_valid, frame_err, overrun_err, rx_data};
      end
    end
  endtask

  function automatic logic [7:0] exp_byte(input logic [7:0] b, input int flip_bit, input logic maj);
    if (flip_bit < 0 || maj) return b;
    return b ^ (8'd1 << flip_bit);
  endfunction

  initial begin
    logic pv, v1, v2, f1, o1, maj;
    logic [7:0] d1, b;
    logic [10:0] ar;
    int c_f, c_o, c_v;
`ifdef UART_RX_MAJORITY_EN
    maj = 1'b1;
`else
    maj = 1'b0;
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", {31'd0, rx_valid}, 32'd0);
    chk("reset_data", {24'd0, rx_data}, 32'd0);
    chk("reset_errs", {30'd0, frame_err, overrun_err}, 32'd0);
    rst = 1'b0;
    rx_ready = 1'b1;
    idle_ticks(3);

    send_frame(8'hA5, 1'b1, -1, -1, 1'b0, pv, v1, v2, f1, o1, d1, ar);
    chk("a5_pre_valid", {31'd0, pv}, 32'd0);
    chk("a5_valid", {31'd0, v1}, 32'd1);
    chk("a5_data", {24'd0, d1}, 32'hA5);
    chk("a5_errs", {30'd0, f1, o1}, 32'd0);
    chk("a5_valid_1clk", {31'd0, v2}, 32'd0);
    idle_ticks(2);

    c_f = n_ferr; c_o = n_oerr; c_v = n_vrise;
    rx = 1'b0;
    repeat (4) next_tick(1'b0);
    idle_ticks(20);
    chk("glitch_valid", n_vrise - c_v, 0);
    chk("glitch_errs", (n_ferr - c_f) + (n_oerr - c_o), 0);
    send_frame(8'h3C, 1'b1, -1, -1, 1'b0, pv, v1, v2, f1, o1, d1, ar);
    chk("post_glitch_data", {24'd0, d1}, 32'h3C);
    chk("post_glitch_valid", {31'd0, v1}, 32'd1);
    idle_ticks(2);

    c_f = n_ferr; c_v = n_vrise;
    send_frame(8'h3C, 1'b0, -1, -1, 1'b0, pv, v1, v2, f1, o1, d1, ar);
    chk("ferr_pulse", {31'd0, f1}, 32'd1);
    chk("ferr_no_valid", {31'd0, v1}, 32'd0);
    rx = 1'b0;
    repeat (40) next_tick(1'b0);
    idle_ticks(3);
    chk("ferr_count", n_ferr - c_f, 1);
    chk("ferr_no_vrise", n_vrise - c_v, 0);
    send_frame(8'h55, 1'b1, -1, -1, 1'b0, pv, v1, v2, f1, o1, d1, ar);
    chk("after_break_data", {24'd0, d1}, 32'h55);
    chk("after_break_valid", {31'd0, v1}, 32'd1);
    idle_ticks(2);

    rx_ready = 1'b0;
    c_o = n_oerr;
    send_frame(8'h11, 1'b1, -1, -1, 1'b0, pv, v1, v2, f1, o1, d1, ar);
    chk("ovr_first_data", {24'd0, d1}, 32'h11);
    chk("ovr_first_held", {31'd0, v2}, 32'd1);
    idle_ticks(2);
    send_frame(8'h22, 1'b1, -1, -1, 1'b0, pv, v1, v2, f1, o1, d1, ar);
    chk("ovr_pulse", {31'd0, o1}, 32'd1);
    chk("ovr_data_kept", {24'd0, d1}, 32'h11);
    chk("ovr_valid_kept", {31'd0, v1}, 32'd1);
    idle_ticks(2);
    send_frame(8'h22, 1'b1, -1, -1, 1'b1, pv, v1, v2, f1, o1, d1, ar);
    chk("same_cycle_no_ovr", {31'd0, o1}, 32'd0);
    chk("same_cycle_data", {24'd0, d1}, 32'h22);
    chk("same_cycle_valid", {31'd0, v2}, 32'd1);
    chk("ovr_count", n_oerr - c_o, 1);
    idle_ticks(2);

    c_v = n_vrise;
    send_frame(8'hFF, 1'b1, -1, 70, 1'b0, pv, v1, v2, f1, o1, d1, ar);
    chk("midframe_rst_outputs", {21'd0, ar}, 32'd0);
    chk("midframe_no_valid", n_vrise - c_v, 0);
    rx_ready = 1'b1;
    idle_ticks(2);
    send_frame(8'h81, 1'b1, -1, -1, 1'b0, pv, v1, v2, f1, o1, d1, ar);
    chk("post_rst_data", {24'd0, d1}, 32'h81);
    chk("post_rst_valid", {31'd0, v1}, 32'd1);
    idle_ticks(2);

    send_frame(8'h0F, 1'b1, 89, -1, 1'b0, pv, v1, v2, f1, o1, d1, ar);
    chk("flip_bit4_data", {24'd0, d1}, {24'd0, exp_byte(8'h0F, 4, maj)});
    idle_ticks(2);

    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom_range(255, 0));
      send_frame(b, 1'b1, -1, -1, 1'b0, pv, v1, v2, f1, o1, d1, ar);
      chk("rand_data", {24'd0, d1}, {24'd0, exp_byte(b, -1, maj)});
      chk("rand_valid_errs", {29'd0, v1, f1, o1}, 32'b100);
      idle_ticks(1 + int'($urandom_range(3, 0)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_rx.md
# uart_rx

Oversampling UART receiver that sits directly downstream of the baud generator. It consumes the generator's 16x oversample tick, recovers 8N1 frames (LSB first) from the asynchronous serial line, and presents each byte on a valid/ready interface to the host logic. Framing and overrun errors are reported as single-cycle pulses.

## Interface
- `DATA_BITS`, default 8: data bits per frame, LSB first.
- `OVERSAMPLE`, default 16: ticks per bit. Must match the baud generator. Must be even and ≥ 8.

- `clk`, in, 1: system clock.
- `rst`, in, 1: synchronous, active-high reset.
- `tick_16x`, in, 1: one-`clk` oversample strobe from the baud generator.
- `rx`, in, 1: asynchronous serial line; idles high.
- `rx_data`, out, `DATA_BITS`: received byte; valid while `rx_valid` is high.
- `rx_valid`, out, 1: byte available; held until consumed.
- `rx_ready`, in, 1: consumer accepts the byte when `rx_valid && rx_ready`.
- `frame_err`, out, 1: one-cycle pulse when the stop bit is sampled low.
- `overrun_err`, out, 1: one-cycle pulse when a byte completes while the previous byte is unconsumed.

## Operation
- **Synchroniser:** `rx` passes through a 2-FF synchroniser, giving `rx_s`. Both FFs reset to 1. All decisions use `rx_s`.
- **State and counters:**
  - `cnt` is a tick counter of width `$clog2(OVERSAMPLE)`.
  - `bit_idx` counts received data bits.
  - States advance only on cycles where `tick_16x` = 1.
- **IDLE:** on a tick with `rx_s` = 0 → START, `cnt` = 0.
- **START:** `cnt` increments per tick. At `cnt == OVERSAMPLE/2-1`, sample `rx_s`:
  - 0 → DATA, `cnt` = 0, `bit_idx` = 0.
  - 1 → IDLE (glitch rejection; no output, no error).
- **DATA:** at `cnt == OVERSAMPLE-1`, sample, shift the bit in at the MSB (LSB-first reconstruction), `cnt` = 0, `bit_idx++`. After the `DATA_BITS`-th sample → STOP.
- **STOP:** at `cnt == OVERSAMPLE-1`, sample:
  - 1 → deliver the byte and go to IDLE.
  - 0 → pulse `frame_err`, discard the byte, go to BREAK_WAIT.
- **BREAK_WAIT:** stay until a tick with `rx_s` = 1, then go to IDLE. A line held low (break) therefore produces exactly one `frame_err`.
- **Delivery:** the cycle after the stop sample, one of the following applies:
  - `rx_valid` = 0, or (`rx_valid` = 1 and `rx_ready` = 1 that same cycle): load `rx_data` and set `rx_valid` = 1.
  - `rx_valid` = 1 and `rx_ready` = 0: keep the old `rx_data`, discard the new byte, pulse `overrun_err`.
- **Consumption:** `rx_valid && rx_ready` with no simultaneous delivery clears `rx_valid` on the next cycle.

## Timing
- **Reset values:** `rx_data` = 0, `rx_valid` = 0, `frame_err` = 0, `overrun_err` = 0; state = IDLE; `cnt` = 0; `bit_idx` = 0.
- **Mid-frame reset:** any reset mid-frame aborts the frame with no error pulse.
- **Sample points (OVERSAMPLE = 16):** counting from the tick that detects start, the start check is 8 ticks later. Data bit k is sampled at 8+16(k+1) ticks. The stop bit is sampled at 8+16·(`DATA_BITS`+1) ticks, which is 152 ticks for 8 bits.
- **Output latency:** `rx_valid`, `frame_err` and `overrun_err` assert exactly 1 `clk` after the stop-sample tick. Error pulses last exactly 1 `clk`.
- **Synchroniser latency:** 2 `clk`. Edge detection resolution is 1 tick.
- **`tick_16x` stuck low:** the FSM freezes in its current state. The handshake continues to operate.

## Configuration
- `UART_RX_MAJORITY_EN` defined:
  - Each START/DATA/STOP decision is the 2-of-3 majority of `rx_s` at `cnt` = target−2, target−1 and target.
  - The start-check target is `OVERSAMPLE/2-1`; the DATA/STOP target is `OVERSAMPLE-1`.
  - Sample points and latency are unchanged.
- Undefined: single sample at the target tick only. Majority registers are not built.

## Test plan
Bench drives `tick_16x` every 7 `clk`, with a bit period of 16 ticks.
- Send 0xA5 (stop = 1) with `rx_ready` = 1 → `rx_data` = 0xA5, `rx_valid` high for 1 `clk`, 1 `clk` after the stop sample; no errors.
- Pull `rx` low for 4 ticks, then high → no `rx_valid`, no error; FSM returns to IDLE. A following 0x3C frame is received correctly.
- Send 0x3C with stop = 0, hold `rx` low for 40 ticks, then send 0x55 → exactly one `frame_err` pulse and no `rx_valid` for 0x3C; then `rx_data` = 0x55.
- With `rx_ready` = 0, send 0x11 then 0x22 → `rx_data` stays 0x11 and `rx_valid` stays 1; one `overrun_err` pulse at the 0x22 stop. Then raise `rx_ready` only on the 0x22 completion cycle → `rx_data` = 0x22, no overrun.
- Assert `rst` for 1 `clk` during data bit 3 of 0xFF → all outputs 0. The next frame 0x81 is received as 0x81.
- With `UART_RX_MAJORITY_EN`: invert `rx` for the single tick at the data-bit-4 sample point of 0x0F → `rx_data` = 0x0F. Without the macro → `rx_data` = 0x1F.
